// File: rtl/but_debounce_pkg.sv
// Shared definitions for the button conditioner: channel state encodings,
// default timing constants and a small edge helper.
package but_debounce_pkg;

    typedef enum logic [1:0] {
        CH_REL       = 2'd0,
        CH_PRESSED   = 2'd1,
        CH_LONG_DONE = 2'd2
    } ch_state_e;

    localparam int DEF_CLK_DIV_W = 12;
    localparam int DEF_DEB_CNT   = 240;
    localparam int DEF_LONG_CNT  = 24414;
    localparam int DEF_CNT_W     = 15;

    function automatic logic rose(input logic cur, input logic prev);
        return cur & ~prev;
    endfunction

endpackage

// File: rtl/but_debounce_if.sv
// Button bundle: raw active-low inputs and the conditioned levels/pulses.
interface but_debounce_if;
    logic BUT1;
    logic BUT2;
    logic BUT1_LVL;
    logic BUT2_LVL;
    logic BUT1_PRESS;
    logic BUT2_PRESS;
    logic BUT1_REL;
    logic BUT2_REL;
    logic BUT1_LONG;
    logic BUT2_LONG;
    logic COMBO;

    modport master (
        output BUT1, BUT2,
        input  BUT1_LVL, BUT2_LVL, BUT1_PRESS, BUT2_PRESS,
        input  BUT1_REL, BUT2_REL, BUT1_LONG, BUT2_LONG, COMBO
    );

    modport slave (
        input  BUT1, BUT2,
        output BUT1_LVL, BUT2_LVL, BUT1_PRESS, BUT2_PRESS,
        output BUT1_REL, BUT2_REL, BUT1_LONG, BUT2_LONG, COMBO
    );
endinterface

// File: rtl/but_debounce_ch.sv
// One button channel: 2-FF synchroniser, tick-based debounce, hold counter
// and the REL/PRESSED/LONG_DONE state machine with its one-cycle pulses.
module but_debounce_ch
    import but_debounce_pkg::*;
#(
    parameter int DEB_CNT  = DEF_DEB_CNT,
    parameter int LONG_CNT = DEF_LONG_CNT,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic but_raw,
    output logic lvl,
    output logic press,
    output logic rel,
    output logic long_p
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CNT - 1);
    localparam logic [CNT_W-1:0] LONG_LIM = CNT_W'(LONG_CNT);

    logic             sync1_r;
    logic             sync2_r;
    logic             sample_s;
    logic [CNT_W-1:0] dcnt_r;
    logic [CNT_W-1:0] hcnt_r;
    logic             lvl_r;
    logic             press_r;
    logic             rel_r;
    logic             long_r;
    logic             press_nxt_s;
    logic             rel_nxt_s;
    logic             long_nxt_s;
    ch_state_e        state_r;
    ch_state_e        state_nxt_s;

    assign sample_s = ~sync2_r;

    // Synchroniser, preset to released so reset never looks like a press
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= but_raw;
            sync2_r <= sync1_r;
        end
    end

    // Debounce: DEB_CNT consecutive disagreeing ticks flip the level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dcnt_r <= CNT_ZERO;
            lvl_r  <= 1'b0;
        end else if (tick) begin
            if (sample_s != lvl_r) begin
                if (dcnt_r == DEB_LAST) begin
                    lvl_r  <= sample_s;
                    dcnt_r <= CNT_ZERO;
                end else begin
                    dcnt_r <= dcnt_r + CNT_ONE;
                end
            end else begin
                dcnt_r <= CNT_ZERO;
            end
        end
    end

    // Hold counter saturates at LONG_CNT so a very long press cannot wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt_r <= CNT_ZERO;
        end else if (state_r == CH_REL) begin
            hcnt_r <= CNT_ZERO;
        end else if (tick && (state_r == CH_PRESSED) && (hcnt_r != LONG_LIM)) begin
            hcnt_r <= hcnt_r + CNT_ONE;
        end
    end

    // State and pulse registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= CH_REL;
            press_r <= 1'b0;
            rel_r   <= 1'b0;
            long_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            press_r <= press_nxt_s;
            rel_r   <= rel_nxt_s;
            long_r  <= long_nxt_s;
        end
    end

    // Next-state and pulse decode; release takes priority over long-press
    always_comb begin
        state_nxt_s = state_r;
        press_nxt_s = 1'b0;
        rel_nxt_s   = 1'b0;
        long_nxt_s  = 1'b0;
        case (state_r)
            CH_REL: begin
                if (lvl_r) begin
                    state_nxt_s = CH_PRESSED;
                    press_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = CH_REL;
                end
            end
            CH_PRESSED: begin
                if (!lvl_r) begin
                    state_nxt_s = CH_REL;
                    rel_nxt_s   = 1'b1;
                end else if (hcnt_r == LONG_LIM) begin
                    state_nxt_s = CH_LONG_DONE;
                    long_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = CH_PRESSED;
                end
            end
            CH_LONG_DONE: begin
                if (!lvl_r) begin
                    state_nxt_s = CH_REL;
                    rel_nxt_s   = 1'b1;
                end else begin
                    state_nxt_s = CH_LONG_DONE;
                end
            end
            default: begin
                state_nxt_s = CH_REL;
            end
        endcase
    end

    assign lvl    = lvl_r;
    assign press  = press_r;
    assign rel    = rel_r;
    assign long_p = long_r;

endmodule

// File: rtl/but_debounce.sv
// Two-button input conditioner: shared tick divider, two debounce channels
// and the both-buttons combo detector with release-to-rearm.
module but_debounce
    import but_debounce_pkg::*;
#(
    parameter int CLK_DIV_W = DEF_CLK_DIV_W,
    parameter int DEB_CNT   = DEF_DEB_CNT,
    parameter int LONG_CNT  = DEF_LONG_CNT,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic           CLK,
    input  logic           RST,
    but_debounce_if.slave  bus
);

    localparam logic [CLK_DIV_W-1:0] DIV_ONE = {{(CLK_DIV_W-1){1'b0}}, 1'b1};

    logic [CLK_DIV_W-1:0] div_r;
    logic                 tick_s;
    logic                 lvl1_s;
    logic                 lvl2_s;
    logic                 both_s;
    logic                 both_q_r;
    logic                 armed_r;
    logic                 combo_r;

    assign tick_s = &div_r;

    // Free-running tick divider
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            div_r <= {CLK_DIV_W{1'b0}};
        end else begin
            div_r <= div_r + DIV_ONE;
        end
    end

    but_debounce_ch #(
        .DEB_CNT  (DEB_CNT),
        .LONG_CNT (LONG_CNT),
        .CNT_W    (CNT_W)
    ) u_ch1 (
        .clk     (CLK),
        .rst     (RST),
        .tick    (tick_s),
        .but_raw (bus.BUT1),
        .lvl     (lvl1_s),
        .press   (bus.BUT1_PRESS),
        .rel     (bus.BUT1_REL),
        .long_p  (bus.BUT1_LONG)
    );

    but_debounce_ch #(
        .DEB_CNT  (DEB_CNT),
        .LONG_CNT (LONG_CNT),
        .CNT_W    (CNT_W)
    ) u_ch2 (
        .clk     (CLK),
        .rst     (RST),
        .tick    (tick_s),
        .but_raw (bus.BUT2),
        .lvl     (lvl2_s),
        .press   (bus.BUT2_PRESS),
        .rel     (bus.BUT2_REL),
        .long_p  (bus.BUT2_LONG)
    );

    assign both_s = lvl1_s & lvl2_s;

    // Combo fires once per both-held episode; only a full release rearms it
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            both_q_r <= 1'b0;
            armed_r  <= 1'b1;
            combo_r  <= 1'b0;
        end else begin
            both_q_r <= both_s;
            combo_r  <= rose(both_s, both_q_r) & armed_r;
            if (!lvl1_s && !lvl2_s) begin
                armed_r <= 1'b1;
            end else if (rose(both_s, both_q_r)) begin
                armed_r <= 1'b0;
            end
        end
    end

    assign bus.BUT1_LVL = lvl1_s;
    assign bus.BUT2_LVL = lvl2_s;
    assign bus.COMBO    = combo_r;

endmodule

// File: tb/tb_but_debounce.sv
// Directed bench for but_debounce with a 4-clock tick, DEB_CNT=4, LONG_CNT=10.
module tb_but_debounce;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    but_debounce_if bif ();

    but_debounce #(
        .CLK_DIV_W (2),
        .DEB_CNT   (4),
        .LONG_CNT  (10),
        .CNT_W     (15)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bif)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // pulse / level event counters, sampled on the falling edge
    int p1 = 0, p2 = 0, r1 = 0, r2 = 0, l1 = 0, l2 = 0;
    int cmb = 0, simul = 0, rise1 = 0, fall1 = 0, wide = 0;
    logic q_p1 = 1'b0, q_p2 = 1'b0, q_r1 = 1'b0, q_r2 = 1'b0;
    logic q_l1 = 1'b0, q_l2 = 1'b0, q_c = 1'b0, q_lvl1 = 1'b0;

    always @(negedge CLK) begin
        if (bif.BUT1_PRESS === 1'b1) p1 <= p1 + 1;
        if (bif.BUT2_PRESS === 1'b1) p2 <= p2 + 1;
        if (bif.BUT1_REL   === 1'b1) r1 <= r1 + 1;
        if (bif.BUT2_REL   === 1'b1) r2 <= r2 + 1;
        if (bif.BUT1_LONG  === 1'b1) l1 <= l1 + 1;
        if (bif.BUT2_LONG  === 1'b1) l2 <= l2 + 1;
        if (bif.COMBO      === 1'b1) cmb <= cmb + 1;
        if ((bif.COMBO === 1'b1) && (bif.BUT1_PRESS === 1'b1) && (bif.BUT2_PRESS === 1'b1))
            simul <= simul + 1;
        if ((bif.BUT1_LVL === 1'b1) && !q_lvl1) rise1 <= rise1 + 1;
        if ((bif.BUT1_LVL === 1'b0) && q_lvl1)  fall1 <= fall1 + 1;
        if ((q_p1 && bif.BUT1_PRESS === 1'b1) || (q_p2 && bif.BUT2_PRESS === 1'b1) ||
            (q_r1 && bif.BUT1_REL === 1'b1)   || (q_r2 && bif.BUT2_REL === 1'b1)   ||
            (q_l1 && bif.BUT1_LONG === 1'b1)  || (q_l2 && bif.BUT2_LONG === 1'b1)  ||
            (q_c && bif.COMBO === 1'b1))
            wide <= wide + 1;
        q_p1   <= (bif.BUT1_PRESS === 1'b1);
        q_p2   <= (bif.BUT2_PRESS === 1'b1);
        q_r1   <= (bif.BUT1_REL === 1'b1);
        q_r2   <= (bif.BUT2_REL === 1'b1);
        q_l1   <= (bif.BUT1_LONG === 1'b1);
        q_l2   <= (bif.BUT2_LONG === 1'b1);
        q_c    <= (bif.COMBO === 1'b1);
        q_lvl1 <= (bif.BUT1_LVL === 1'b1);
    end

    task automatic chk_val(input string tag, input int got, input int exp);
        total = total + 1;
        if (got != exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge CLK);
    endtask

    function automatic int outs();
        return int'({bif.BUT1_LVL, bif.BUT2_LVL, bif.BUT1_PRESS, bif.BUT2_PRESS,
                     bif.BUT1_REL, bif.BUT2_REL, bif.BUT1_LONG, bif.BUT2_LONG, bif.COMBO});
    endfunction

    int s_p1, s_p2, s_r1, s_r2, s_l2, s_c, s_sim;

    initial begin
        // reset with both buttons held
        bif.BUT1 = 1'b0;
        bif.BUT2 = 1'b0;
        RST = 1'b1;
        run(5);
        chk_val("reset_outs", outs(), 0);

        // held across reset: press within 2 + 4*4 + 2 clocks, no release
        bif.BUT2 = 1'b1;
        RST = 1'b0;
        run(20);
        chk_val("held_lvl1", int'(bif.BUT1_LVL), 1);
        chk_val("held_press1", p1, 1);
        chk_val("held_rel1", r1, 0);
        chk_val("held_combo", cmb, 0);
        bif.BUT1 = 1'b1;
        run(28);
        chk_val("rel1_cnt", r1, 1);
        chk_val("rel1_lvl", int'(bif.BUT1_LVL), 0);

        // bounce: 3 ticks low, 1 high, then 4 low
        s_p1 = p1;
        bif.BUT1 = 1'b0; run(12);
        bif.BUT1 = 1'b1; run(4);
        bif.BUT1 = 1'b0; run(12);
        chk_val("bounce_early_press", p1 - s_p1, 0);
        chk_val("bounce_early_lvl", int'(bif.BUT1_LVL), 0);
        run(16);
        chk_val("bounce_press", p1 - s_p1, 1);
        chk_val("bounce_lvl", int'(bif.BUT1_LVL), 1);
        chk_val("bounce_rises", rise1, 2);
        chk_val("bounce_falls", fall1, 1);
        bif.BUT1 = 1'b1;
        run(28);

        // long press on button 2
        s_p2 = p2; s_r2 = r2; s_l2 = l2;
        bif.BUT2 = 1'b0;
        run(72);
        chk_val("long_fire", l2 - s_l2, 1);
        run(80);
        chk_val("long_once", l2 - s_l2, 1);
        bif.BUT2 = 1'b1;
        run(28);
        chk_val("long_rel", r2 - s_r2, 1);
        chk_val("long_rel_lvl", int'(bif.BUT2_LVL), 0);
        bif.BUT2 = 1'b0;
        run(20);
        bif.BUT2 = 1'b1;
        run(40);
        chk_val("short_press", p2 - s_p2, 2);
        chk_val("short_rel", r2 - s_r2, 2);
        chk_val("short_nolong", l2 - s_l2, 1);

        // simultaneous press of both buttons
        s_p1 = p1; s_p2 = p2; s_c = cmb; s_sim = simul;
        bif.BUT1 = 1'b0;
        bif.BUT2 = 1'b0;
        run(28);
        chk_val("sim_press1", p1 - s_p1, 1);
        chk_val("sim_press2", p2 - s_p2, 1);
        chk_val("sim_same_clk", simul - s_sim, 1);
        run(40);
        chk_val("sim_combo_once", cmb - s_c, 1);
        bif.BUT1 = 1'b1;
        bif.BUT2 = 1'b1;
        run(28);

        // rearm: hold BUT1, tap BUT2 twice, then full release and repeat
        s_c = cmb;
        bif.BUT1 = 1'b0; run(28);
        bif.BUT2 = 1'b0; run(28);
        bif.BUT2 = 1'b1; run(28);
        bif.BUT2 = 1'b0; run(28);
        chk_val("rearm_tap_once", cmb - s_c, 1);
        bif.BUT1 = 1'b1;
        bif.BUT2 = 1'b1;
        run(28);
        chk_val("rearm_released", int'({bif.BUT1_LVL, bif.BUT2_LVL}), 0);
        bif.BUT1 = 1'b0; run(28);
        bif.BUT2 = 1'b0; run(28);
        chk_val("rearm_again", cmb - s_c, 2);
        bif.BUT1 = 1'b1;
        bif.BUT2 = 1'b1;
        run(28);

        // async reset mid-debounce with BUT2 accepted as pressed
        bif.BUT2 = 1'b0; run(28);
        chk_val("pre_rst_lvl2", int'(bif.BUT2_LVL), 1);
        s_p1 = p1; s_r1 = r1; s_r2 = r2; s_c = cmb;
        bif.BUT1 = 1'b0;
        run(10);
        #2 RST = 1'b1;
        #1 chk_val("async_rst_outs", outs(), 0);
        run(3);
        bif.BUT1 = 1'b1;
        bif.BUT2 = 1'b1;
        run(2);
        RST = 1'b0;
        run(30);
        chk_val("async_no_press1", p1 - s_p1, 0);
        chk_val("async_no_rel", (r1 - s_r1) + (r2 - s_r2), 0);
        chk_val("async_no_combo", cmb - s_c, 0);
        chk_val("async_idle_outs", outs(), 0);

        chk_val("pulse_width", wide, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
